// File: rtl/shift_right.sv
// Combinational right shift by SHIFT bits with PAD_VALUE filling the vacated MSBs.
// Mirror of shift_left; SHIFT == WIDTH yields an all-pad word.
module shift_right #(
  parameter int   WIDTH     = 8,
  parameter int   SHIFT     = 1,
  parameter logic PAD_VALUE = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [WIDTH-1:0] ONES     = '1;
  // Ones in the top SHIFT positions only when padding with 1.
  localparam logic [WIDTH-1:0] PAD_MASK = PAD_VALUE ? ~(ONES >> SHIFT) : '0;

  assign dout = (din >> SHIFT) | PAD_MASK;

endmodule

// File: rtl/shift_right_serializer.sv
// Parallel-to-serial converter: loads a WIDTH-bit word and emits it LSB-first
// in SHIFT-bit beats over a valid/ready stream, one IDLE cycle between words.
module shift_right_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   SHIFT     = 1,
  parameter logic PAD_VALUE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_data,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  output logic [SHIFT-1:0] serial_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             busy
);

  if (WIDTH < 1 || SHIFT < 1 || SHIFT > WIDTH || (WIDTH % SHIFT) != 0) begin : g_bad_params
    $error("shift_right_serializer: illegal WIDTH/SHIFT combination");
  end

  localparam int BEATS = WIDTH / SHIFT;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic {IDLE = 1'b0, SHIFTING = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;

  shift_right #(
    .WIDTH    (WIDTH),
    .SHIFT    (SHIFT),
    .PAD_VALUE(PAD_VALUE)
  ) u_shift (
    .din (sreg_q),
    .dout(sreg_shifted)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= {WIDTH{PAD_VALUE}};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (parallel_valid) begin
          state_d = SHIFTING;
          sreg_d  = parallel_data;
          cnt_d   = CW'(BEATS);
        end
      end
      SHIFTING: begin
        // Counter only moves on a beat handshake, so it cannot underflow.
        if (serial_ready) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    parallel_ready = (state_q == IDLE);
    serial_valid   = (state_q == SHIFTING);
    busy           = (state_q == SHIFTING);
    serial_data    = sreg_q[SHIFT-1:0];
  end

endmodule

// File: tb/tb_shift_right_serializer.sv
// Directed and randomized checks of shift_right_serializer in 8x1, 8x2 and 8x8 configurations.
module tb_shift_right_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pd    = '0;
  logic       pv1 = 1'b0, pv2 = 1'b0, pv8 = 1'b0;
  logic       sr    = 1'b0;

  logic       pr1, sv1, bz1;
  logic [0:0] sd1;
  logic       pr2, sv2, bz2;
  logic [1:0] sd2;
  logic       pr8, sv8, bz8;
  logic [7:0] sd8;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  shift_right_serializer #(.WIDTH(8), .SHIFT(1), .PAD_VALUE(1'b0)) u_a (
    .clock(clock), .reset(reset), .parallel_data(pd), .parallel_valid(pv1),
    .parallel_ready(pr1), .serial_data(sd1), .serial_valid(sv1),
    .serial_ready(sr), .busy(bz1));

  shift_right_serializer #(.WIDTH(8), .SHIFT(2), .PAD_VALUE(1'b0)) u_b (
    .clock(clock), .reset(reset), .parallel_data(pd), .parallel_valid(pv2),
    .parallel_ready(pr2), .serial_data(sd2), .serial_valid(sv2),
    .serial_ready(sr), .busy(bz2));

  shift_right_serializer #(.WIDTH(8), .SHIFT(8), .PAD_VALUE(1'b0)) u_c (
    .clock(clock), .reset(reset), .parallel_data(pd), .parallel_valid(pv8),
    .parallel_ready(pr8), .serial_data(sd8), .serial_valid(sv8),
    .serial_ready(sr), .busy(bz8));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_pr"}, 32'(pr1), 32'd1);
    chk({tag, "_sv"}, 32'(sv1), 32'd0);
    chk({tag, "_busy"}, 32'(bz1), 32'd0);
  endtask

  // Load a word into the 8x1 instance; returns with the first beat presented.
  task automatic load_a(input logic [7:0] w);
    pd  = w;
    pv1 = 1'b1;
    step();
    pv1 = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bits;
    logic [7:0] word, got;
    logic [1:0] exp2 [4];
    int n, guard;
    logic lost;

    // Reset state
    step(); step();
    reset = 1'b0;
    chk_idle_a("rst_a");
    chk("rst_a_sd", 32'(sd1), 32'd0);
    chk("rst_b_sd", 32'(sd2), 32'd0);
    chk("rst_b_pr", 32'(pr2), 32'd1);
    chk("rst_c_sd", 32'(sd8), 32'd0);
    chk("rst_c_sv", 32'(sv8), 32'd0);

    // Basic 8x1: 0xB4 -> 0,0,1,0,1,1,0,1
    sr = 1'b1;
    load_a(8'hB4);
    chk("b4_pr", 32'(pr1), 32'd0);
    chk("b4_busy", 32'(bz1), 32'd1);
    exp_bits = 8'b1011_0100;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b4_beat%0d_sv", i), 32'(sv1), 32'd1);
      chk($sformatf("b4_beat%0d_sd", i), 32'(sd1), 32'(exp_bits[i]));
      step();
    end
    chk_idle_a("b4_end");

    // Multi-bit beats 8x2 and single-beat 8x8, both loaded with 0xB4
    exp2[0] = 2'b00; exp2[1] = 2'b01; exp2[2] = 2'b11; exp2[3] = 2'b10;
    pd = 8'hB4; pv2 = 1'b1; pv8 = 1'b1;
    step();
    pv2 = 1'b0; pv8 = 1'b0;
    chk("w8_sv", 32'(sv8), 32'd1);
    chk("w8_sd", 32'(sd8), 32'hB4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_beat%0d_sv", i), 32'(sv2), 32'd1);
      chk($sformatf("s2_beat%0d_sd", i), 32'(sd2), 32'(exp2[i]));
      step();
      if (i == 0) begin
        chk("w8_end_sv", 32'(sv8), 32'd0);
        chk("w8_end_pr", 32'(pr8), 32'd1);
      end
    end
    chk("s2_end_sv", 32'(sv2), 32'd0);
    chk("s2_end_pr", 32'(pr2), 32'd1);

    // Backpressure: 0x01 held 5 cycles, then 1 followed by 7 zeros
    sr = 1'b0;
    load_a(8'h01);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_sv", i), 32'(sv1), 32'd1);
      chk($sformatf("bp_hold%0d_sd", i), 32'(sd1), 32'd1);
      step();
    end
    sr = 1'b1;
    chk("bp_beat0_sd", 32'(sd1), 32'd1);
    step();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("bp_beat%0d_sv", i), 32'(sv1), 32'd1);
      chk($sformatf("bp_beat%0d_sd", i), 32'(sd1), 32'd0);
      step();
    end
    chk_idle_a("bp_end");

    // Load ignored while busy: 0x6A with a 0xFF pulse after beat 3
    load_a(8'h6A);
    exp_bits = 8'h6A;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin pd = 8'hFF; pv1 = 1'b1; end
      if (i == 5) pv1 = 1'b0;
      chk($sformatf("ign_beat%0d_sd", i), 32'(sd1), 32'(exp_bits[i]));
      chk($sformatf("ign_beat%0d_pr", i), 32'(pr1), 32'd0);
      step();
    end
    chk_idle_a("ign_end");

    // Reset mid-word: 0xC3, reset after 3 beats (with handshake pending)
    load_a(8'hC3);
    exp_bits = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rmw_beat%0d_sd", i), 32'(sd1), 32'(exp_bits[i]));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_a("rmw_rst");
    chk("rmw_rst_sd", 32'(sd1), 32'd0);
    load_a(8'h5A);
    exp_bits = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rmw_new%0d_sv", i), 32'(sv1), 32'd1);
      chk($sformatf("rmw_new%0d_sd", i), 32'(sd1), 32'(exp_bits[i]));
      step();
    end
    chk_idle_a("rmw_end");

    // Random traffic: reassemble 1000 words under random serial_ready
    for (int w = 0; w < 1000; w++) begin
      word = 8'($urandom);
      chk("rnd_pr", 32'(pr1), 32'd1);
      load_a(word);
      got = '0; n = 0; guard = 0; lost = 1'b0;
      while (n < 8 && guard < 200) begin
        sr = 1'($urandom_range(0, 1));
        if (!sv1) lost = 1'b1;
        else if (sr) begin
          got[n] = sd1[0];
          n++;
        end
        step();
        guard++;
      end
      chk("rnd_missing", 32'(lost), 32'd0);
      chk("rnd_beats", 32'(n), 32'd8);
      chk("rnd_extra", 32'(sv1), 32'd0);
      chk("rnd_word", 32'(got), 32'(word));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_right_serializer.md
SHIFT_RIGHT_SERIALIZER -- requirements
Module: shift_right_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: parallel word width in bits; legal range is at least 1.
REQ-002 The block SHALL have parameter SHIFT, default 1: bits emitted per serial beat; legal range is 1 to WIDTH with WIDTH % SHIFT == 0, and an elaboration-time error otherwise.
REQ-003 The block SHALL have parameter PAD_VALUE, default 1'b0: the bit value shifted in at the MSB end.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port parallel_data, input, WIDTH bits: word to serialize.
REQ-007 The block SHALL have port parallel_valid, input, 1 bit: parallel_data is valid.
REQ-008 The block SHALL have port parallel_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port serial_data, output, SHIFT bits: current beat, LSB-first order.
REQ-010 The block SHALL have port serial_valid, output, 1 bit: serial_data is valid.
REQ-011 The block SHALL have port serial_ready, input, 1 bit: the sink accepts the beat.
REQ-012 The block SHALL have port busy, output, 1 bit: a word is being serialized.

Function
REQ-013 The block SHALL have two states: IDLE and SHIFTING.
REQ-014 In IDLE, parallel_ready SHALL be 1, serial_valid 0, and busy 0.
REQ-015 In SHIFTING, parallel_ready SHALL be 0, serial_valid 1, and busy 1.
REQ-016 A parallel handshake (parallel_valid and parallel_ready both high at a rising edge) SHALL load parallel_data into the shift register, set the beat counter to WIDTH/SHIFT, and enter SHIFTING on the next cycle.
REQ-017 serial_data SHALL equal shift_register[SHIFT-1:0], driven directly from flops with no combinational path from any input.
REQ-018 A serial handshake (serial_valid and serial_ready both high at a rising edge) SHALL shift the register right by SHIFT, fill the SHIFT MSBs with PAD_VALUE, and decrement the counter.
REQ-019 The handshake that consumes the last beat (counter == 1) SHALL return the block to IDLE.
REQ-020 Latency SHALL be exactly 1 cycle from the parallel handshake to the first serial_valid.
REQ-021 Minimum occupancy per word SHALL be WIDTH/SHIFT + 1 cycles, because one IDLE cycle separates consecutive words.
REQ-022 While serial_ready is low in SHIFTING, serial_data, the counter and the register SHALL hold their values.
REQ-023 The block SHALL ignore parallel_valid while in SHIFTING; data on parallel_data is neither captured nor lost-tracked.
REQ-024 The counter SHALL be $clog2(WIDTH/SHIFT + 1) bits wide and SHALL never wrap.
REQ-025 When SHIFT == WIDTH, each word SHALL produce exactly one beat equal to parallel_data.
REQ-026 The pad value SHALL never appear on serial_data within a word; padding is internal only.

Reset
REQ-027 When reset is high at a rising edge, state SHALL become IDLE, the register all PAD_VALUE, and the counter 0.
REQ-028 Out of reset, parallel_ready SHALL be 1 and serial_valid, busy and serial_data SHALL be 0 (serial_data {SHIFT{PAD_VALUE}}).
REQ-029 Reset SHALL take priority over any simultaneous handshake; an in-flight word is discarded with no further beats.

Structure
REQ-030 No shared package SHALL be used; the state enum is local to the module.
REQ-031 The next-register value SHALL be computed by instantiating the combinational sub-module shift_right (parameters WIDTH, SHIFT, PAD_VALUE), the mirror of shift_left.
REQ-032 The block SHALL contain a single state register, the data register and the counter, with no latches.

Verification
REQ-033 Verify the basic sequence: WIDTH=8, SHIFT=1, load 0xB4, serial_ready=1 -> beats 0,0,1,0,1,1,0,1 on 8 consecutive cycles, then 1 IDLE cycle.
REQ-034 Verify multi-bit beats: WIDTH=8, SHIFT=2, load 0xB4 -> beats 2'b00, 2'b01, 2'b11, 2'b10, then IDLE.
REQ-035 Verify backpressure: load 0x01 and hold serial_ready low for 5 cycles -> serial_data stays 1 with serial_valid stable, then 7 zeros once ready rises.
REQ-036 Verify that loads are ignored while busy: pulse parallel_valid with 0xFF mid-word -> no effect, and the original word completes intact.
REQ-037 Verify reset mid-word: assert reset after beat 3 -> next cycle IDLE, serial_valid 0, parallel_ready 1, and a fresh word serializes correctly.
REQ-038 Verify randomized traffic: 1000 words with random serial_ready -> reassembled words match the inputs and there are no extra or missing beats.
